// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_framed
// Description : UART receive channel. Oversampling tick generator, 2-flop rx
//               synchroniser, 3-sample majority bit decision, configurable
//               word length / parity / stop bits, false-start rejection,
//               break detection and an output FIFO with valid/ready handshake.
// Ports       : clock, reset      - single clock, synchronous active-high reset
//               rx                - asynchronous serial input, idle high
//               m_data            - head word, LSB = first bit on the line
//               m_parity_err      - head word failed the parity check
//               m_frame_err       - head word had a stop bit sampled as 0
//               m_break           - head word was a line break
//               m_valid/m_ready   - head handshake
//               overrun           - pulse when a completed word is dropped
//               fifo_count        - FIFO occupancy
//               busy              - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 16,
    parameter int BAUDRATE     = 115200,
    parameter int CLOCK_INPUT  = 50_000_000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_parity_err,
    output logic                        m_frame_err,
    output logic                        m_break,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy
);
    localparam int c_DIV_RAW = CLOCK_INPUT / (BAUDRATE * OVERSAMPLING);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_TW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SW      = $clog2(OVERSAMPLING);
    localparam int c_MID     = OVERSAMPLING / 2;
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_WW      = DATA_BITS + 3;

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
    localparam logic [c_SW-1:0] c_SC_LAST   = c_SW'(OVERSAMPLING - 1);
    localparam logic [c_SW-1:0] c_SC_V0     = c_SW'(c_MID - 1);
    localparam logic [c_SW-1:0] c_SC_V1     = c_SW'(c_MID);
    localparam logic [c_SW-1:0] c_SC_V2     = c_SW'(c_MID + 1);
    localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_ONE       = (c_AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state, w_next_state;

    logic                 r_sync1, r_sync2, r_sync3;
    logic [c_TW-1:0]      r_tick_cnt;
    logic [c_SW-1:0]      r_sc;
    logic [1:0]           r_vote;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_stop_first, r_frame_err;
    logic                 r_push;
    logic [c_WW-1:0]      r_push_word;

    logic                 w_tick, w_sample, w_decide, w_bit, w_fall, w_last_stop;
    logic [c_SW-1:0]      w_sc_next;
    logic                 w_first_stop, w_data_par, w_parity_err, w_break, w_frame_err;
    logic [c_WW-1:0]      w_word;

    // Tick counter only runs inside a frame, so its phase starts at the edge.
    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == c_TICK_LAST);
    assign w_sc_next = (r_sc == c_SC_LAST) ? '0 : r_sc + c_SW'(1);
    // Samples are taken on the ticks that move sc to Mid-1, Mid, Mid+1, so the
    // decision for bit k lands on tick k*OVERSAMPLING + Mid+1 after the edge.
    assign w_sample  = w_tick && ((w_sc_next == c_SC_V0) || (w_sc_next == c_SC_V1) ||
                                  (w_sc_next == c_SC_V2));
    assign w_decide  = w_tick && (w_sc_next == c_SC_V2);
    // Third vote is the live synchronised sample at the decision tick.
    assign w_bit     = (r_vote[1] & r_vote[0]) | (r_vote[1] & r_sync2) | (r_vote[0] & r_sync2);
    assign w_fall    = r_sync3 & ~r_sync2;

    always_comb begin
        w_next_state = r_state;
        w_last_stop  = 1'b0;
        case (r_state)
            S_IDLE:   if (w_fall) w_next_state = S_START;
            S_START:  if (w_decide) w_next_state = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_decide && (r_bit_idx == c_DATA_LAST))
                          w_next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_decide) w_next_state = S_STOP;
            S_STOP:   if (w_decide && (r_bit_idx == c_STOP_LAST)) begin
                          w_next_state = S_IDLE;
                          w_last_stop  = 1'b1;
                      end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Word assembly at the last stop decision; the first stop bit may be the
    // bit being decided right now when STOP_BITS is 1.
    always_comb begin
        w_first_stop = (r_bit_idx == 4'd0) ? w_bit : r_stop_first;
        w_data_par   = (^r_shift) ^ r_par_bit;
        w_parity_err = (PARITY_MODE == 1) ? w_data_par :
                       (PARITY_MODE == 2) ? ~w_data_par : 1'b0;
        w_break      = (r_shift == '0) && ((PARITY_MODE == 0) || !r_par_bit) && !w_first_stop;
        w_frame_err  = r_frame_err | ~w_bit;
        w_word       = {w_break, w_frame_err, w_parity_err, r_shift};
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync3      <= 1'b1;
            r_tick_cnt   <= '0;
            r_sc         <= '0;
            r_vote       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_stop_first <= 1'b0;
            r_frame_err  <= 1'b0;
            r_push       <= 1'b0;
            r_push_word  <= '0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            if ((r_state == S_IDLE) || (r_tick_cnt == c_TICK_LAST)) r_tick_cnt <= '0;
            else                                                    r_tick_cnt <= r_tick_cnt + c_TW'(1);

            if (r_state == S_IDLE) r_sc <= '0;
            else if (w_tick)       r_sc <= w_sc_next;

            if (w_sample) r_vote <= {r_vote[0], r_sync2};

            if (w_next_state != r_state) r_bit_idx <= '0;
            else if (w_decide)           r_bit_idx <= r_bit_idx + 4'd1;

            if ((r_state == S_DATA) && w_decide) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if ((r_state == S_PARITY) && w_decide) r_par_bit <= w_bit;

            if (r_state == S_START) r_frame_err <= 1'b0;
            if ((r_state == S_STOP) && w_decide) begin
                if (r_bit_idx == 4'd0) r_stop_first <= w_bit;
                if (!w_bit)            r_frame_err  <= 1'b1;
            end

            r_push <= w_last_stop;
            if (w_last_stop) r_push_word <= w_word;
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO. The head entry is mirrored in a register so the outputs only
    // move on a pop or on a push into an empty FIFO.
    // ------------------------------------------------------------------------
    logic [c_WW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;
    logic [c_WW-1:0] r_head;
    logic            r_valid, r_overrun;
    logic            w_pop, w_full, w_push_ok;
    logic [c_AW-1:0] w_rptr_next;

    assign w_pop       = r_valid & m_ready;
    assign w_full      = (r_count == c_FULL);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok   = r_push & (~w_full | w_pop);
    assign w_rptr_next = r_rptr + c_AW'(1);

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wptr] <= r_push_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push & w_full & ~w_pop;
            if (w_push_ok) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)     r_rptr <= w_rptr_next;

            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                if (r_count > c_ONE) r_head  <= r_mem[w_rptr_next];
                else if (w_push_ok)  r_head  <= r_push_word;
                else                 r_valid <= 1'b0;
            end else if (w_push_ok && (r_count == '0)) begin
                r_head  <= r_push_word;
                r_valid <= 1'b1;
            end
        end
    end

    assign m_data       = r_head[DATA_BITS-1:0];
    assign m_parity_err = r_head[DATA_BITS];
    assign m_frame_err  = r_head[DATA_BITS+1];
    assign m_break      = r_head[DATA_BITS+2];
    assign m_valid      = r_valid;
    assign overrun      = r_overrun;
    assign fifo_count   = r_count;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_framed
// Description : Self-checking bench for uart_rx_framed. Frames are built from
//               their bit fields; the expected FIFO entry of each frame is
//               derived from the framing rules and queued, and every pop is
//               checked against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framed;
    localparam int c_BAUD   = 115200;
    localparam int c_CLK_IN = 64 * c_BAUD;
    localparam int c_BIT    = 64;
    localparam int c_DEPTH  = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_parity_err, m_frame_err, m_break, m_valid, overrun, busy;
    logic [2:0] fifo_count;

    uart_rx_framed #(
        .DATA_BITS   (8),
        .PARITY_MODE (1),
        .STOP_BITS   (1),
        .OVERSAMPLING(16),
        .BAUDRATE    (c_BAUD),
        .CLOCK_INPUT (c_CLK_IN),
        .FIFO_DEPTH  (c_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .m_data      (m_data),
        .m_parity_err(m_parity_err),
        .m_frame_err (m_frame_err),
        .m_break     (m_break),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overrun     (overrun),
        .fifo_count  (fifo_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          n_ovr   = 0;
    int          exp_ovr = 0;
    logic [10:0] exp_q[$];
    logic [10:0] last_word = '0;
    logic [10:0] mon_got;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Entry = {break, frame_err, parity_err, data}; even parity.
    function automatic logic [10:0] frame_entry(input logic [7:0] d, input logic par, input logic stp);
        logic pe, fe, brk;
        pe  = (^d) ^ par;
        fe  = ~stp;
        brk = (d == 8'h00) && !par && !stp;
        return {brk, fe, pe, d};
    endfunction

    // Compare process: every accepted head word must match the model queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (overrun) n_ovr++;
            if (m_valid && m_ready) begin
                mon_got   = {m_break, m_frame_err, m_parity_err, m_data};
                last_word = mon_got;
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, required no word", mon_got);
                end else begin
                    check("pop", 32'(mon_got), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #2;
            m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        step(c_BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        if (exp_q.size() >= c_DEPTH) exp_ovr++;
        else                         exp_q.push_back(frame_entry(d, par, stp));
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
        rx = 1'b1;
    endtask

    initial begin
        int          p0;
        int          o0;
        logic [7:0]  d;
        logic        par;
        logic        stp;

        reset   = 1'b1;
        rx      = 1'b1;
        m_ready = 1'b0;
        step(5);
        reset = 1'b0;
        step(2);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_flags", 32'({m_break, m_frame_err, m_parity_err}), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(busy), 0);

        // Clean word
        m_ready = 1'b1;
        step(c_BIT);
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_busy_end", 32'(busy), 0);
        step(4);
        check("a5_word", 32'(last_word), 32'h0A5);
        check("a5_pops", 32'(n_pops), 1);

        // Parity error
        send_frame(8'h3C, 1'b1, 1'b1);
        step(4);
        check("3c_word", 32'(last_word), 32'h13C);

        // Framing error
        send_frame(8'h81, 1'b0, 1'b0);
        step(c_BIT);
        check("81_word", 32'(last_word), 32'h281);

        // Break: line low for 20 bit times gives exactly one word
        p0 = n_pops;
        exp_q.push_back(frame_entry(8'h00, 1'b0, 1'b0));
        rx = 1'b0;
        step(20 * c_BIT);
        check("brk_pops", 32'(n_pops - p0), 1);
        check("brk_word", 32'(last_word), 32'h600);
        check("brk_busy", 32'(busy), 0);
        rx = 1'b1;
        step(2 * c_BIT);
        send_frame(8'h5A, 1'b0, 1'b1);
        step(4);
        check("after_brk_word", 32'(last_word), 32'h05A);

        // False start
        p0 = n_pops;
        rx = 1'b0;
        step(10);
        check("glitch_busy", 32'(busy), 1);
        step(10);
        rx = 1'b1;
        step(100);
        check("glitch_idle", 32'(busy), 0);
        check("glitch_count", 32'(fifo_count), 0);
        check("glitch_pops", 32'(n_pops - p0), 0);

        // Overrun with a stalled consumer
        m_ready = 1'b0;
        o0 = n_ovr;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(d, ^d, 1'b1);
        end
        step(5);
        check("ovr_count", 32'(fifo_count), 4);
        check("ovr_pulses", 32'(n_ovr - o0), 1);
        check("ovr_model", 32'(n_ovr), 32'(exp_ovr));
        check("ovr_head", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        step(10);
        check("ovr_drained", 32'(exp_q.size()), 0);
        check("ovr_last", 32'(last_word), 32'h004);
        check("ovr_empty", 32'(fifo_count), 0);

        // Reset during data bit 3 with two words held
        m_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        step(2);
        check("rst2_count_before", 32'(fifo_count), 2);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        step(c_BIT / 2);
        check("rst2_busy_before", 32'(busy), 1);
        reset = 1'b1;
        exp_q.delete();
        step(1);
        reset = 1'b0;
        check("rst2_count", 32'(fifo_count), 0);
        check("rst2_valid", 32'(m_valid), 0);
        check("rst2_busy", 32'(busy), 0);
        step(2 * c_BIT);
        m_ready = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1);
        step(4);
        check("rst2_next_word", 32'(last_word), 32'h055);

        // Randomised frames with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom);
            par = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            stp = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d   = 8'h00;
                par = 1'b0;
                stp = 1'b0;
            end
            send_frame(d, par, stp);
            if (!stp || ($urandom_range(0, 1) == 1))
                step(c_BIT * int'($urandom_range(1, 2)));
        end
        step(c_BIT);
        rand_ready = 1'b0;
        step(1);
        m_ready = 1'b1;
        step(10);
        check("rand_drained", 32'(exp_q.size()), 0);
        check("rand_empty", 32'(fifo_count), 0);
        check("rand_overruns", 32'(n_ovr), 32'(exp_ovr));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
